// File: rtl/even_parity_tx32.sv
// Transmit side of the even/odd parity serial link: captures a parallel word on a
// valid/ready handshake and shifts it out LSB first, followed by its parity bit.
module even_parity_tx32 #(
    parameter int DATA_W = 31,
    parameter bit ODD    = 1'b0,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              sout,
    output logic              sout_valid,
    input  logic              sout_ready,
    output logic              sout_last,
    output logic              parity_out,
    output logic [CNT_W-1:0]  ones_out,
    output logic              busy
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAR  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
    logic               parity_q, parity_d;
    logic [CNT_W-1:0]   ones_q, ones_d;

    logic               word_parity;
    logic [CNT_W-1:0]   word_ones;

    // Parity and ones-count of the word on the input bus, used only at acceptance.
    always_comb begin
        word_parity = (^in) ^ ODD;
        word_ones   = '0;
        for (int i = 0; i < DATA_W; i++) begin
            word_ones = word_ones + {{(CNT_W-1){1'b0}}, in[i]};
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        parity_d   = parity_q;
        ones_d     = ones_q;
        in_ready   = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        sout_last  = 1'b0;
        busy       = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = rst_n;
                if (in_valid) begin
                    shreg_d  = in;
                    bitcnt_d = '0;
                    parity_d = word_parity;
                    ones_d   = word_ones;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                busy       = 1'b1;
                sout_valid = 1'b1;
                sout       = shreg_q[0];
                if (sout_ready) begin
                    shreg_d  = {1'b0, shreg_q[DATA_W-1:1]};
                    bitcnt_d = bitcnt_q + BIT_W'(1);
                    if (bitcnt_q == BIT_W'(DATA_W - 1)) begin
                        state_d = S_PAR;
                    end
                end
            end
            S_PAR: begin
                busy       = 1'b1;
                sout_valid = 1'b1;
                sout_last  = 1'b1;
                sout       = parity_q;
                if (sout_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            parity_q <= 1'b0;
            ones_q   <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            parity_q <= parity_d;
            ones_q   <= ones_d;
        end
    end

    assign parity_out = parity_q;
    assign ones_out   = ones_q;

endmodule

// File: tb/tb_even_parity_tx32.sv
// Randomised self-checking bench for even_parity_tx32, compared against a
// frame-level model built from $countones and bit indexing of each accepted word.
module tb_even_parity_tx32;

   logic        clk;
   logic        rst_n;
   logic [30:0] in;
   logic        in_valid;
   logic        in_ready;
   logic        sout;
   logic        sout_valid;
   logic        sout_ready;
   logic        sout_last;
   logic        parity_out;
   logic [4:0]  ones_out;
   logic        busy;

   logic        in_ready_odd;
   logic        sout_odd;
   logic        sout_valid_odd;
   logic        sout_last_odd;
   logic        parity_out_odd;
   logic [4:0]  ones_out_odd;
   logic        busy_odd;

   int checks;
   int failures;

   even_parity_tx32 #(.DATA_W(31), .ODD(1'b0), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .in_ready(in_ready),
      .sout(sout), .sout_valid(sout_valid), .sout_ready(sout_ready), .sout_last(sout_last),
      .parity_out(parity_out), .ones_out(ones_out), .busy(busy)
   );

   even_parity_tx32 #(.DATA_W(31), .ODD(1'b1), .CNT_W(5)) dut_odd (
      .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .in_ready(in_ready_odd),
      .sout(sout_odd), .sout_valid(sout_valid_odd), .sout_ready(sout_ready), .sout_last(sout_last_odd),
      .parity_out(parity_out_odd), .ones_out(ones_out_odd), .busy(busy_odd)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something wedges outside a bounded loop.
   initial begin
      #2000000;
      $display("[TB] FAIL globalTimeout observed=running required=finished");
      $fatal(1, "[TB] global timeout");
   end

   // Every comparison funnels through here so the counters stay honest.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h required=0x%0h", tag, observed, expected);
      end
   endtask

   // Sends one word and drains its frame, comparing every handshaked bit against
   // the model. mode 0 = ready always high, 1 = random ready, 2 = ready pattern 1,0,0,1.
   // When interfere is set, in_valid stays high with otherWord during the frame.
   task automatic applyStimulus(input logic [30:0] word, input int mode,
                                input bit interfere, input logic [30:0] otherWord);
      logic [31:0] expFrame;
      logic [31:0] gotFrame;
      logic [3:0]  pat;
      logic        expPar;
      int          expOnes;
      int          taken;
      int          lastIdx;
      int          lastCount;
      int          cycles;
      bit          prevStall;
      logic        prevSout;

      expOnes  = $countones(word);
      expPar   = expOnes[0];
      expFrame = {expPar, word};
      gotFrame = '0;
      pat      = 4'b1001;
      taken    = 0;
      lastIdx  = -1;
      lastCount = 0;
      cycles   = 0;
      prevStall = 1'b0;
      prevSout  = 1'b0;

      checkOutput("readyBeforeAccept", {31'b0, in_ready}, 32'd1);
      in       = word;
      in_valid = 1'b1;
      sout_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      cycles = 1;
      checkOutput("onesOut", {27'b0, ones_out}, 32'(expOnes));
      checkOutput("parityOut", {31'b0, parity_out}, {31'b0, expPar});
      checkOutput("parityOutOdd", {31'b0, parity_out_odd}, {31'b0, ~expPar});
      if (interfere) begin
         in = otherWord;
      end else begin
         in_valid = 1'b0;
         in = 31'($urandom);
      end

      while (lastCount == 0 && cycles < 500) begin
         case (mode)
            0: sout_ready = 1'b1;
            1: sout_ready = 1'($urandom_range(0, 1));
            default: sout_ready = pat[(cycles - 1) % 4];
         endcase
         checkOutput("busyInFrame", {30'b0, in_ready, busy}, 32'd1);
         checkOutput("validInFrame", {31'b0, sout_valid}, 32'd1);
         checkOutput("statsHeld", {26'b0, parity_out, ones_out}, {26'b0, expPar, 5'(expOnes)});
         if (prevStall) begin
            checkOutput("stallStable", {31'b0, sout}, {31'b0, prevSout});
         end
         if (sout_valid && sout_ready) begin
            if (taken < 32) begin
               gotFrame[taken] = sout;
            end
            if (sout_last) begin
               lastIdx = taken;
               lastCount++;
               checkOutput("oddParityBit", {31'b0, sout_odd}, {31'b0, ~expPar});
            end
            taken++;
         end
         prevStall = sout_valid && !sout_ready;
         prevSout  = sout;
         @(posedge clk);
         @(negedge clk);
         cycles++;
      end

      if (cycles >= 500) begin
         checkOutput("frameTimeout", 32'd1, 32'd0);
      end
      checkOutput("frameBits", gotFrame, expFrame);
      checkOutput("handshakes", 32'(taken), 32'd32);
      checkOutput("lastPosition", 32'(lastIdx), 32'd31);
      checkOutput("frameEvenWeight", 32'($countones(gotFrame) % 2), 32'd0);
      checkOutput("readyAfterFrame", {29'b0, in_ready, busy, sout_valid}, 32'd4);
      checkOutput("statsAfterFrame", {26'b0, parity_out, ones_out}, {26'b0, expPar, 5'(expOnes)});
      if (mode == 0) begin
         checkOutput("frameCycles", 32'(cycles), 32'd33);
      end
      sout_ready = 1'($urandom_range(0, 1));
   endtask

   initial begin
      logic [30:0] w;
      checks   = 0;
      failures = 0;
      rst_n      = 1'b0;
      in         = '0;
      in_valid   = 1'b0;
      sout_ready = 1'b0;

      // Reset values while rst_n is held low.
      @(negedge clk);
      in_valid = 1'b1;
      @(negedge clk);
      checkOutput("resetReady", {31'b0, in_ready}, 32'd0);
      checkOutput("resetOutputs", {26'b0, sout, sout_valid, sout_last, parity_out, busy, 1'b0},
                  32'd0);
      checkOutput("resetOnes", {27'b0, ones_out}, 32'd0);
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      // Directed frames from the test plan.
      applyStimulus(31'h0000_0001, 0, 1'b0, 31'h0);
      applyStimulus(31'h7FFF_FFFF, 0, 1'b0, 31'h0);
      applyStimulus(31'h0000_0000, 0, 1'b0, 31'h0);
      applyStimulus(31'h5555_5555, 2, 1'b0, 31'h0);
      applyStimulus(31'h0F0F_00FF, 1, 1'b1, 31'h1234_5678);
      applyStimulus(31'h1234_5678, 0, 1'b0, 31'h0);
      checkOutput("ones12345678", {27'b0, ones_out}, 32'd13);

      // Abort a frame while bit 10 is being presented.
      w = 31'($urandom);
      in = w;
      in_valid = 1'b1;
      sout_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
      checkOutput("bit10Value", {31'b0, sout}, {31'b0, w[10]});
      rst_n = 1'b0;
      #1;
      checkOutput("abortOutputs", {26'b0, sout, sout_valid, sout_last, parity_out, busy, in_ready},
                  32'd0);
      checkOutput("abortOnes", {27'b0, ones_out}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("abortQuiet", {31'b0, sout_valid}, 32'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("readyAfterAbort", {30'b0, in_ready, sout_valid}, 32'd2);
      @(negedge clk);
      applyStimulus(31'($urandom), 0, 1'b0, 31'h0);

      // Random words under random backpressure.
      for (int n = 0; n < 12; n++) begin
         applyStimulus(31'($urandom), 1, 1'($urandom_range(0, 1)), 31'($urandom));
      end
      in_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/even_parity_tx32.md
Name: even_parity_tx32

Overview:
- Transmit-side counterpart of the 32-bit even-parity check path.
- Accepts a 31-bit parallel word on a valid/ready handshake and computes its parity bit and ones-count.
- Serialises the 32-bit frame LSB first: 31 data bits, then the parity bit, with downstream backpressure.
- Sits between the word producer and the serial link whose far end runs the parity checker.

Parameters:
- DATA_W, 31, data bits per frame; frame length is DATA_W+1.
- ODD, 0, 0 = even parity (total ones in frame even), 1 = odd parity.
- CNT_W, 5, width of ones_out; must be >= ceil(log2(DATA_W+1)).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in  input  DATA_W  parallel data word.
- in_valid  input  1  word on `in` is valid.
- in_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial frame bit.
- sout_valid  output  1  sout holds a frame bit.
- sout_ready  input  1  downstream consumes sout this cycle.
- sout_last  output  1  current bit is the parity bit (last bit of frame).
- parity_out  output  1  parity bit of the last accepted word.
- ones_out  output  CNT_W  number of 1s in the last accepted word (data bits only).
- busy  output  1  a frame is in flight.

Behaviour:
- Reset (async assert, sync deassert by design above):
  - State goes to IDLE.
  - sout=0, sout_valid=0, sout_last=0, parity_out=0, ones_out=0, busy=0.
  - in_ready=0 while rst_n=0.
  - Shift register and bit counter are cleared.
- States: IDLE, DATA, PAR.
- IDLE:
  - in_ready=1, sout_valid=0, busy=0.
  - Accept on in_valid & in_ready at a clock edge. At that edge:
    - shreg <= in; bitcnt <= 0.
    - parity_out <= (^in) ^ ODD.
    - ones_out <= popcount(in), zero-extended to CNT_W.
    - State <= DATA.
- DATA:
  - in_ready=0, busy=1, sout_valid=1, sout=shreg[0], sout_last=0.
  - On sout_ready: shreg shifts right by one and bitcnt increments.
  - When bitcnt==DATA_W-1 and sout_ready, state <= PAR.
  - Without sout_ready, all state holds; sout is stable.
- PAR:
  - sout=parity_out, sout_valid=1, sout_last=1, busy=1.
  - On sout_ready, state <= IDLE.
- Latency and throughput:
  - First data bit appears the cycle after acceptance.
  - With sout_ready held high, a frame occupies DATA_W+1 cycles.
  - in_ready returns one cycle after the parity bit is taken, giving one idle cycle between frames.
- Arithmetic:
  - ones_out counts 0..DATA_W and never wraps for the legal CNT_W.
  - Even mode: parity_out = XOR of data; the 32-bit frame has even weight.
- in_valid while busy: ignored; the word is not captured; in_ready stays 0.
- parity_out and ones_out hold until the next acceptance.
- in change while not accepted: no effect.
- Reset mid-frame: frame aborts immediately; outputs take reset values; the next frame starts only after a new accept.
- sout_ready high while sout_valid=0: no effect.

Test Plan:
- Reset then in=31'h0000_0001, in_valid=1, sout_ready=1 -> accepted on first edge after reset release. ones_out=1, parity_out=1. sout sequence 1, then 30 zeros, then parity 1 with sout_last=1. in_ready high again on cycle 33.
- in=31'h7FFF_FFFF -> ones_out=31, parity_out=1. Frame = 31 ones then 1 (32 ones, even). With ODD=1: parity_out=0.
- in=31'h0 -> ones_out=0, parity_out=0. Frame is all zeros, sout_last only on bit 31. Checker loopback reports confirm=1.
- Backpressure: sout_ready toggles 1,0,0,1 repeatedly on in=31'h5555_5555 -> sout holds during low cycles. Frame bits are 1,0,1,0,..., then parity 0 (16 ones). Total handshakes = 32.
- in_valid held with in=31'h1234_5678 during a frame -> not captured; ones_out/parity_out unchanged until IDLE. The word is then accepted: ones_out=13, parity_out=1.
- rst_n pulled low at bit 10 of a frame -> sout_valid/busy fall asynchronously, with no further bits. After release, in_ready=1 and a fresh word frames correctly from bit 0.
